next_serial_sender: RTL and testbench

- Parametrised successor to the single-buffer NeXT serial packet sender. Serialises one frame per audio-request tick.
- Frame layout, in order:
  - request/underrun slot, 1+DATA_W bits
  - GAP_BITS idle bits
  - data slot, 1+DATA_W bits
- Outbound words are queued in a FIFO of configurable depth instead of a single buffer.
- Sits between the host-side packet encoder and the serial `sout` line to the keyboard/monitor link.

---
 rtl/next_sender_pkg.sv | 26 ++
 rtl/next_sync_fifo.sv | 78 +++++++
 rtl/next_serial_sender.sv | 167 ++++++++++++++++
 tb/tb_next_serial_sender.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/next_sender_pkg.sv
// -----------------------------------------------------------------------------
// next_sender_pkg
// Shared types and constants for the NeXT serial packet sender.
//   state_e            : frame sequencer states (IDLE, REQ, GAP, DAT)
//   DEF_REQ_CODE       : default payload of the audio sample request packet
//   DEF_UNDERRUN_CODE  : default payload of the audio underrun packet
//   frame_len()        : number of serial cycles one frame occupies after tick
// -----------------------------------------------------------------------------
package next_sender_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DAT  = 2'd3
  } state_e;

  localparam logic [39:0] DEF_REQ_CODE      = 40'h0700000000;
  localparam logic [39:0] DEF_UNDERRUN_CODE = 40'h0f00000000;

  // Request slot + idle gap + data slot, each slot carrying a marker bit.
  function automatic int frame_len(input int data_w, input int gap_bits);
    return 2 * (1 + data_w) + gap_bits;
  endfunction

endpackage

// File: rtl/next_sync_fifo.sv
// -----------------------------------------------------------------------------
// next_sync_fifo
// Single-clock FIFO, DATA_W wide and DEPTH entries deep (DEPTH a power of two).
// Ports:
//   clk, rst  : clock and synchronous active-high reset (clears pointers/count)
//   push_i    : write data_i; ignored while full, even if a pop happens too
//   data_i    : word to write
//   pop_i     : discard the head word; ignored while empty
//   data_o    : current head word
//   full_o    : DEPTH words held
//   empty_o   : no words held
//   count_o   : number of words held
// -----------------------------------------------------------------------------
module next_sync_fifo #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Flags come from the registered count, so a same-cycle pop never frees
  // room for a push into a full FIFO.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure data; stale words are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/next_serial_sender.sv
// -----------------------------------------------------------------------------
// next_serial_sender
// Serialises one frame per audio-request tick onto sout, MSB (marker) first:
//   request/underrun slot (1+DATA_W bits), GAP_BITS zeros, data slot
//   (1+DATA_W bits). Data slot words come from an outbound FIFO.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_data, in_valid, in_ready    : word push interface (push = valid & ready)
//   audio_sample_request_mode      : request packet in the request slot
//   audio_sample_request_underrun  : underrun packet (wins over mode)
//   audio_sample_request_tick      : one-cycle frame start strobe
//   sout                           : serial output, one bit per cycle
//   data_loss                      : pulse when a push is rejected (FIFO full)
//   data_sent                      : pulse when a FIFO word enters the data slot
//   busy                           : a frame is in progress
// Optional (macro NEXT_SENDER_TICK_MISS_EN):
//   tick_missed                    : pulse when a tick arrives while busy
//   miss_count                     : saturating count of missed ticks
// -----------------------------------------------------------------------------
module next_serial_sender
  import next_sender_pkg::*;
#(
  parameter int                DATA_W        = 40,
  parameter int                FIFO_DEPTH    = 4,
  parameter int                GAP_BITS      = 3,
  parameter logic [DATA_W-1:0] REQ_CODE      = DATA_W'(DEF_REQ_CODE),
  parameter logic [DATA_W-1:0] UNDERRUN_CODE = DATA_W'(DEF_UNDERRUN_CODE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              audio_sample_request_mode,
  input  logic              audio_sample_request_underrun,
  input  logic              audio_sample_request_tick,
  output logic              sout,
  output logic              data_loss,
  output logic              data_sent,
  output logic              busy
`ifdef NEXT_SENDER_TICK_MISS_EN
  ,
  output logic              tick_missed,
  output logic [7:0]        miss_count
`endif
);

  localparam int FRAME_LEN = frame_len(DATA_W, GAP_BITS);
  // One counter width that covers every state's bit count.
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int FCNT_W    = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   shift_q, shift_d;

  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

  next_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ready  = (fifo_count != FCNT_W'(FIFO_DEPTH));
  assign data_loss = in_valid & ~in_ready;
  assign busy      = (state_q != IDLE);
  assign sout      = ((state_q == REQ) || (state_q == DAT)) & shift_q[DATA_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    shift_d   = {shift_q[DATA_W-1:0], 1'b0};
    fifo_pop  = 1'b0;
    data_sent = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        shift_d = shift_q;
        // Mode/underrun matter only on the tick cycle.
        if (audio_sample_request_tick) begin
          state_d = REQ;
          if (audio_sample_request_underrun)  shift_d = {1'b1, UNDERRUN_CODE};
          else if (audio_sample_request_mode) shift_d = {1'b1, REQ_CODE};
          else                                shift_d = '0;
        end
      end
      REQ: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        shift_d = '0;
        // The data slot is loaded on the last gap cycle so its marker bit
        // lands on the first DAT cycle.
        if (cnt_q == CNT_W'(GAP_BITS - 1)) begin
          state_d = DAT;
          cnt_d   = '0;
          if (!fifo_empty) begin
            shift_d   = {1'b1, fifo_head};
            fifo_pop  = 1'b1;
            data_sent = 1'b1;
          end
        end
      end
      DAT: begin
        // A tick on the last DAT cycle is not honoured: IDLE must be seen.
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Flags and occupancy of the FIFO must never disagree.
  assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_count == FCNT_W'(FIFO_DEPTH)));

`ifdef NEXT_SENDER_TICK_MISS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  logic [7:0] miss_count_q;

  assign tick_missed = audio_sample_request_tick & busy;
  assign miss_count  = miss_count_q;

  always_ff @(posedge clk) begin
    if (rst)              miss_count_q <= '0;
    else if (tick_missed) miss_count_q <= sat_inc8(miss_count_q);
  end
`endif

endmodule

// File: tb/tb_next_serial_sender.sv
module tb_next_serial_sender;

  localparam int DW      = 40;
  localparam int DEPTH   = 4;
  localparam int GAPB    = 3;
  localparam int FL      = 2 * (1 + DW) + GAPB;   // 85
  localparam int POP_POS = DW + GAPB;             // last gap cycle (43)
  localparam int DAT_POS = DW + 1 + GAPB;         // first data bit (44)
  localparam logic [DW-1:0] REQC = 40'h0700000000;
  localparam logic [DW-1:0] UNDC = 40'h0f00000000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mode = 1'b0, und = 1'b0, tick = 1'b0;
  logic          sout, data_loss, data_sent, busy;
`ifdef NEXT_SENDER_TICK_MISS_EN
  logic          tick_missed;
  logic [7:0]    miss_count;
`endif

  next_serial_sender dut (
    .clk                           (clk),
    .rst                           (rst),
    .in_data                       (in_data),
    .in_valid                      (in_valid),
    .in_ready                      (in_ready),
    .audio_sample_request_mode     (mode),
    .audio_sample_request_underrun (und),
    .audio_sample_request_tick     (tick),
    .sout                          (sout),
    .data_loss                     (data_loss),
    .data_sent                     (data_sent),
    .busy                          (busy)
`ifdef NEXT_SENDER_TICK_MISS_EN
    ,
    .tick_missed                   (tick_missed),
    .miss_count                    (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  // Reference model: frame position (-1 = idle), frame bit image, word queue.
  int            m_pos = -1;
  bit            m_fb [FL];
  logic [DW-1:0] m_q [$];
  int            m_miss = 0;

  // Outputs captured in the most recent cycle.
  logic o_sout, o_busy, o_ready, o_loss, o_sent, o_missed;
  logic [7:0] o_mcnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic cyc(input bit r, input bit v, input logic [DW-1:0] d,
                     input bit t, input bit m, input bit u);
    bit          en_pop, en_push, e_busy, e_sout, e_ready, e_loss, e_sent;
    logic [DW:0] w;
    rst = r; in_valid = v; in_data = d; tick = t; mode = m; und = u;
    #1;
    o_sout = sout; o_busy = busy; o_ready = in_ready; o_loss = data_loss; o_sent = data_sent;
`ifdef NEXT_SENDER_TICK_MISS_EN
    o_missed = tick_missed; o_mcnt = miss_count;
`else
    o_missed = 1'b0; o_mcnt = 8'd0;
`endif
    e_busy  = (m_pos >= 0);
    e_sout  = (m_pos >= 0) ? m_fb[m_pos] : 1'b0;
    e_ready = (m_q.size() < DEPTH);
    e_loss  = v && (m_q.size() == DEPTH);
    e_sent  = (m_pos == POP_POS) && (m_q.size() > 0);
    if (chk_en) begin
      chk("sout",      64'(o_sout),  64'(e_sout));
      chk("busy",      64'(o_busy),  64'(e_busy));
      chk("in_ready",  64'(o_ready), 64'(e_ready));
      chk("data_loss", 64'(o_loss),  64'(e_loss));
      chk("data_sent", 64'(o_sent),  64'(e_sent));
`ifdef NEXT_SENDER_TICK_MISS_EN
      chk("tick_missed", 64'(o_missed), 64'(t && (m_pos >= 0)));
      chk("miss_count",  64'(o_mcnt),   64'(m_miss));
`endif
    end
    if (r) begin
      m_pos = -1; m_q.delete(); m_miss = 0;
    end else begin
      en_pop  = (m_pos == POP_POS) && (m_q.size() > 0);
      en_push = v && (m_q.size() < DEPTH);
      if (m_pos == POP_POS) begin
        w = en_pop ? {1'b1, m_q[0]} : '0;
        if (en_pop) void'(m_q.pop_front());
        for (int i = 0; i <= DW; i++) m_fb[DAT_POS + i] = w[DW - i];
      end
      if (en_push) m_q.push_back(d);
      if (t && (m_pos >= 0) && (m_miss < 255)) m_miss++;
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == FL) m_pos = -1;
      end else if (t) begin
        w = u ? {1'b1, UNDC} : (m ? {1'b1, REQC} : '0);
        for (int i = 0; i <= DW; i++) m_fb[i] = w[DW - i];
        for (int i = DW + 1; i < DAT_POS; i++) m_fb[i] = 1'b0;
        m_pos = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 1'($urandom), 1'($urandom));
  endtask

  // Issue a tick and collect the whole frame from sout.
  task automatic run_frame(input bit m, input bit u, output logic [DW:0] rq,
                           output logic [DW:0] dt, output logic gap_or,
                           output int nbusy, output int nsent);
    int j;
    rq = '0; dt = '0; gap_or = 1'b0; nbusy = 0; nsent = 0;
    cyc(0, 0, '0, 1, m, u);
    j = 0;
    do begin
      cyc(0, 0, '0, 0, 1'($urandom), 1'($urandom));
      if (o_busy) begin
        if (j <= DW)           rq[DW - j] = o_sout;
        else if (j < DAT_POS)  gap_or = gap_or | o_sout;
        else if (j < FL)       dt[DW - (j - DAT_POS)] = o_sout;
        nbusy++;
        nsent += int'(o_sent);
      end
      j++;
    end while (o_busy && j < 200);
    if (j >= 200) chk("frame_timeout", 64'(1), 64'(0));
  endtask

  typedef struct {
    bit            push;
    logic [DW-1:0] word;
    bit            m;
    bit            u;
    logic [DW:0]   exp_req;
    logic [DW:0]   exp_dat;
    int            exp_sent;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic [DW:0]   rq, dt;
    logic          gap_or;
    int            nb, ns;
    logic [DW-1:0] pw [5];

    vt[0] = '{0, 40'h0,          0, 0, 41'h0,           41'h0,           0};
    vt[1] = '{1, 40'hD999999991, 1, 0, 41'h10700000000, 41'h1D999999991, 1};
    vt[2] = '{0, 40'h0,          1, 1, 41'h10f00000000, 41'h0,           0};
    vt[3] = '{1, 40'h0123456789, 0, 1, 41'h10f00000000, 41'h10123456789, 1};
    vt[4] = '{1, 40'hFFFFFFFFFF, 0, 0, 41'h0,           41'h1FFFFFFFFFF, 1};

    @(negedge clk);
    cyc(1, 0, '0, 0, 0, 0);
    cyc(1, 0, '0, 0, 0, 0);
    chk_en = 1'b1;

    // Reset state
    cyc(0, 0, '0, 0, 0, 0);
    chk("rst_sout",  64'(o_sout),  64'(0));
    chk("rst_busy",  64'(o_busy),  64'(0));
    chk("rst_ready", 64'(o_ready), 64'(1));
    chk("rst_loss",  64'(o_loss),  64'(0));
    chk("rst_sent",  64'(o_sent),  64'(0));
    chk("rst_mcnt",  64'(o_mcnt),  64'(0));

    // Table-driven single frames
    for (int k = 0; k < 5; k++) begin
      if (vt[k].push) cyc(0, 1, vt[k].word, 0, 0, 0);
      idle(2);
      run_frame(vt[k].m, vt[k].u, rq, dt, gap_or, nb, ns);
      chk($sformatf("vec%0d_req", k),   64'(rq),     64'(vt[k].exp_req));
      chk($sformatf("vec%0d_gap", k),   64'(gap_or), 64'(0));
      chk($sformatf("vec%0d_dat", k),   64'(dt),     64'(vt[k].exp_dat));
      chk($sformatf("vec%0d_busy", k),  64'(nb),     64'(FL));
      chk($sformatf("vec%0d_sent", k),  64'(ns),     64'(vt[k].exp_sent));
    end

    // Five back-to-back pushes into a 4-deep FIFO, then drain over 5 frames
    cyc(1, 0, '0, 0, 0, 0);
    for (int k = 0; k < 5; k++) pw[k] = {8'($urandom), 32'($urandom)};
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, pw[k], 0, 0, 0);
      chk($sformatf("push%0d_ready", k), 64'(o_ready), 64'(k < 4));
      chk($sformatf("push%0d_loss", k),  64'(o_loss),  64'(k == 4));
    end
    cyc(0, 0, '0, 0, 0, 0);
    chk("full_ready", 64'(o_ready), 64'(0));
    chk("full_loss",  64'(o_loss),  64'(0));
    for (int k = 0; k < 5; k++) begin
      run_frame(1, 0, rq, dt, gap_or, nb, ns);
      chk($sformatf("drain%0d_dat", k),  64'(dt), (k < 4) ? 64'({1'b1, pw[k]}) : 64'(0));
      chk($sformatf("drain%0d_sent", k), 64'(ns), 64'(k < 4));
    end

    // Second tick 40 cycles into a frame is ignored
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 0, '0, 1, 1, 0);
    nb = 0;
    for (int k = 1; k < 40; k++) begin
      cyc(0, 0, '0, 0, 0, 0);
      nb += int'(o_busy);
    end
    cyc(0, 0, '0, 1, 0, 1);
    nb += int'(o_busy);
`ifdef NEXT_SENDER_TICK_MISS_EN
    chk("missed_pulse", 64'(o_missed), 64'(1));
`endif
    begin
      int guard = 0;
      do begin
        cyc(0, 0, '0, 0, 0, 0);
        nb += int'(o_busy);
        guard++;
      end while (o_busy && guard < 200);
      if (guard >= 200) chk("miss_timeout", 64'(1), 64'(0));
    end
    chk("miss_frame_len", 64'(nb), 64'(FL));
`ifdef NEXT_SENDER_TICK_MISS_EN
    chk("miss_count_one", 64'(o_mcnt), 64'(1));
`endif

    // Reset in the middle of the data slot with words queued
    cyc(0, 1, 40'h1111111111, 0, 0, 0);
    cyc(0, 1, 40'h2222222222, 0, 0, 0);
    cyc(0, 0, '0, 1, 1, 0);
    idle(60);
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0);
    chk("mrst_sout",  64'(o_sout),  64'(0));
    chk("mrst_busy",  64'(o_busy),  64'(0));
    chk("mrst_ready", 64'(o_ready), 64'(1));
    run_frame(1, 0, rq, dt, gap_or, nb, ns);
    chk("mrst_req",  64'(rq), 64'(41'h10700000000));
    chk("mrst_dat",  64'(dt), 64'(0));
    chk("mrst_sent", 64'(ns), 64'(0));

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 3,
          {8'($urandom), 32'($urandom)}, $urandom_range(0, 29) == 0,
          1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
